sha256_padder: RTL

Message-front-end for the SHA-256 core. Accepts an arbitrary-length byte stream with valid/ready flow control, applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length), and delivers 512-bit blocks to the core one at a time using the core's enable/done handshake. It sits directly upstream of the core and drives its block-data, enable and block-count inputs.

---
 rtl/sha256_padder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: byte-stream front end for the SHA-256 core.
// Pads each message per FIPS 180-4 and hands 512-bit blocks to the core.
//
// Ports:
//   i_clk, i_rst            clock, async active-low reset
//   i_byte/i_valid/i_last   message beat (valid/ready with o_ready)
//   i_keep                  beat carries a byte (0 only with i_last)
//   o_block                 padded block, byte 0 in [511:504]
//   o_enable / i_done       core start pulse / core level-done
//   o_nblocks               blocks issued in current message
//   o_last_block            final block of message issued
//   o_msg_done              final block compression finished (pulse)
//   o_err                   message exceeded MAX_BLOCKS (sticky)
module sha256_padder #(
  parameter int unsigned MAX_BLOCKS = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_byte,
  input  logic         i_valid,
  input  logic         i_last,
  input  logic         i_keep,
  output logic         o_ready,
  output logic [511:0] o_block,
  output logic         o_enable,
  input  logic         i_done,
  output logic [7:0]   o_nblocks,
  output logic         o_last_block,
  output logic         o_msg_done,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_LEN,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_DRAIN
  } state_t;

  state_t       state_q, state_d;
  logic [511:0] blk_q, blk_d;
  logic [6:0]   idx_q, idx_d;
  logic [15:0]  len_q, len_d;
  logic         final_q, final_d;
  logic         padp_q, padp_d;
  logic         lenp_q, lenp_d;
  logic         seen_q, seen_d;
  logic         busy_q, busy_d;
  logic [7:0]   nblk_q, nblk_d;
  logic         lastb_q, lastb_d;
  logic         en_q, en_d;
  logic         mdone_q, mdone_d;
  logic         err_q, err_d;
  logic         rdy;
  logic [63:0]  bitlen;

  assign bitlen = {45'd0, len_q, 3'd0};

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    len_d   = len_q;
    final_d = final_q;
    padp_d  = padp_q;
    lenp_d  = lenp_q;
    seen_d  = seen_q;
    busy_d  = busy_q;
    nblk_d  = nblk_q;
    lastb_d = lastb_q;
    err_d   = err_q;
    en_d    = 1'b0;
    mdone_d = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      S_FILL: begin
        rdy = 1'b1;
        if (i_valid) begin
          busy_d = 1'b1;
          // busy_q low means this is the first beat of a new message
          if (!busy_q) begin
            nblk_d  = 8'd0;
            lastb_d = 1'b0;
            err_d   = 1'b0;
          end
          seen_d = i_last;
          if (i_keep) begin
            for (int i = 0; i < 64; i++) begin
              if (idx_q == 7'(i)) begin
                blk_d[511-8*i -: 8] = i_byte;
              end
            end
            idx_d = idx_q + 7'd1;
            len_d = len_q + 16'd1;
          end
          if (i_keep && idx_q == 7'd63) begin
            state_d = S_ISSUE;
            padp_d  = i_last;
          end else if (i_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < 64; i++) begin
          if (idx_q == 7'(i)) begin
            blk_d[511-8*i -: 8] = 8'h80;
          end else if (7'(i) > idx_q) begin
            blk_d[511-8*i -: 8] = 8'h00;
          end
        end
        // length only fits if the 0x80 landed before byte 56
        if (idx_q <= 7'd55) begin
          blk_d[63:0] = bitlen;
          final_d     = 1'b1;
        end else begin
          lenp_d = 1'b1;
        end
        state_d = S_ISSUE;
      end
      S_LEN: begin
        blk_d   = {448'd0, bitlen};
        final_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_done) begin
          if (nblk_q == MAX_BLOCKS[7:0]) begin
            err_d = 1'b1;
            if (seen_q) begin
              state_d = S_FILL;
              idx_d   = 7'd0;
              len_d   = 16'd0;
              final_d = 1'b0;
              padp_d  = 1'b0;
              lenp_d  = 1'b0;
              seen_d  = 1'b0;
              busy_d  = 1'b0;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            en_d    = 1'b1;
            nblk_d  = nblk_q + 8'd1;
            lastb_d = final_q;
            state_d = S_WAIT_LO;
          end
        end
      end
      S_WAIT_LO: begin
        if (!i_done) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (i_done) begin
          if (final_q) begin
            mdone_d = 1'b1;
            state_d = S_FILL;
            idx_d   = 7'd0;
            len_d   = 16'd0;
            final_d = 1'b0;
            padp_d  = 1'b0;
            lenp_d  = 1'b0;
            seen_d  = 1'b0;
            busy_d  = 1'b0;
          end else if (padp_q) begin
            padp_d  = 1'b0;
            idx_d   = 7'd0;
            state_d = S_PAD;
          end else if (lenp_q) begin
            lenp_d  = 1'b0;
            state_d = S_LEN;
          end else begin
            idx_d   = 7'd0;
            state_d = S_FILL;
          end
        end
      end
      S_DRAIN: begin
        rdy = 1'b1;
        if (i_valid && i_last) begin
          state_d = S_FILL;
          idx_d   = 7'd0;
          len_d   = 16'd0;
          final_d = 1'b0;
          padp_d  = 1'b0;
          lenp_d  = 1'b0;
          seen_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      final_q <= 1'b0;
      padp_q  <= 1'b0;
      lenp_q  <= 1'b0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      nblk_q  <= '0;
      lastb_q <= 1'b0;
      en_q    <= 1'b0;
      mdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      final_q <= final_d;
      padp_q  <= padp_d;
      lenp_q  <= lenp_d;
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      nblk_q  <= nblk_d;
      lastb_q <= lastb_d;
      en_q    <= en_d;
      mdone_q <= mdone_d;
      err_q   <= err_d;
    end
  end

  assign o_ready      = rdy;
  assign o_block      = blk_q;
  assign o_enable     = en_q;
  assign o_nblocks    = nblk_q;
  assign o_last_block = lastb_q;
  assign o_msg_done   = mdone_q;
  assign o_err        = err_q;

endmodule
